// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
// Schedules all writes to the branch target buffer's single write port.
// Branch resolutions from EX and single-entry invalidations are queued in an
// in-order FIFO and retired at most one per cycle when the BTB port is free.
// A full clear first drains the FIFO, then walks every index with an
// invalidate write.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex_*            EX branch resolution (valid/ready, pc, target, taken)
//   inv_*           single-entry invalidate request (valid/ready, pc)
//   clr_req         request a full BTB clear (ignored while clr_busy)
//   clr_busy        clear sequence in progress (drain or walk)
//   clr_done        one-cycle pulse alongside the final clear write
//   btb_ready       BTB write port available this cycle
//   btb_we          registered write strobe
//   btb_wvalid      valid bit written (1 install, 0 invalidate)
//   btb_pc          write PC (index and tag source)
//   btb_target      write target
//   pend_cnt        FIFO occupancy
module btb_update_ctrl #(
   parameter int BTB_SIZE   = 64,
   parameter int BTB_WIDTH  = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ex_valid,
   input  logic [ADDR_WIDTH-1:0]           ex_pc,
   input  logic [ADDR_WIDTH-1:0]           ex_target,
   input  logic                            ex_taken,
   output logic                            ex_ready,
   input  logic                            inv_valid,
   input  logic [ADDR_WIDTH-1:0]           inv_pc,
   output logic                            inv_ready,
   input  logic                            clr_req,
   output logic                            clr_busy,
   output logic                            clr_done,
   input  logic                            btb_ready,
   output logic                            btb_we,
   output logic                            btb_wvalid,
   output logic [ADDR_WIDTH-1:0]           btb_pc,
   output logic [ADDR_WIDTH-1:0]           btb_target,
   output logic [$clog2(FIFO_DEPTH):0]     pend_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_CLEAR
   } state_t;

   state_t                 state;

   // FIFO storage: one entry = {pc, target, wvalid}
   logic [ADDR_WIDTH-1:0]  mem_pc  [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_tgt [FIFO_DEPTH];
   logic                   mem_wv  [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       cnt;

   logic [BTB_WIDTH-1:0]   clr_idx;

   logic                   full;
   logic                   empty;
   logic                   push_ex;
   logic                   push_inv;
   logic                   push;
   logic                   pop;
   logic [ADDR_WIDTH-1:0]  push_pc;
   logic [ADDR_WIDTH-1:0]  push_tgt;
   logic                   push_wv;
   logic [ADDR_WIDTH-1:0]  clr_pc;

   assign full     = (cnt == CNT_W'(FIFO_DEPTH));
   assign empty    = (cnt == '0);

   // Readies are held low while in reset so they first rise the cycle after
   // rst deasserts. No full bypass: a pop in the same cycle does not reopen.
   assign ex_ready  = !rst && (state == S_IDLE) && !full;
   assign inv_ready = !rst && (state == S_IDLE) && !full && !ex_valid;

   assign push_ex  = ex_valid && ex_ready;
   assign push_inv = inv_valid && inv_ready;
   assign push     = push_ex || push_inv;
   assign pop      = ((state == S_IDLE) || (state == S_DRAIN)) && !empty && btb_ready;

   assign clr_busy = (state != S_IDLE);
   assign pend_cnt = cnt;

   always_comb begin
      push_pc  = inv_pc;
      push_tgt = '0;
      push_wv  = 1'b0;
      if (push_ex) begin
         push_pc  = ex_pc;
         push_tgt = ex_target;
         push_wv  = ex_taken;
      end
   end

   // Clear walk address: index placed at pc[BTB_WIDTH+1:2], other bits zero
   always_comb begin
      clr_pc = '0;
      clr_pc[BTB_WIDTH+1:2] = clr_idx;
   end

   // FIFO data array carries no reset; occupancy is tracked by cnt
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]  <= push_pc;
         mem_tgt[wr_ptr] <= push_tgt;
         mem_wv[wr_ptr]  <= push_wv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Control FSM with registered BTB write outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         clr_idx    <= '0;
         clr_done   <= 1'b0;
         btb_we     <= 1'b0;
         btb_wvalid <= 1'b0;
         btb_pc     <= '0;
         btb_target <= '0;
      end else begin
         btb_we   <= 1'b0;
         clr_done <= 1'b0;

         if (pop) begin
            btb_we     <= 1'b1;
            btb_wvalid <= mem_wv[rd_ptr];
            btb_pc     <= mem_pc[rd_ptr];
            btb_target <= mem_tgt[rd_ptr];
         end

         case (state)
            S_IDLE: begin
               if (clr_req) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (empty) begin
                  state   <= S_CLEAR;
                  clr_idx <= '0;
               end
            end
            S_CLEAR: begin
               if (btb_ready) begin
                  btb_we     <= 1'b1;
                  btb_wvalid <= 1'b0;
                  btb_pc     <= clr_pc;
                  btb_target <= '0;
                  clr_idx    <= clr_idx + 1'b1;
                  if (clr_idx == BTB_WIDTH'(BTB_SIZE - 1)) begin
                     state    <= S_IDLE;
                     clr_done <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: directed stimulus, expected BTB writes kept
// in a scoreboard queue and checked by an independent monitor.
module tb_btb_update_ctrl;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic [AW-1:0] ex_pc;
   logic [AW-1:0] ex_target;
   logic          ex_taken;
   logic          ex_ready;
   logic          inv_valid;
   logic [AW-1:0] inv_pc;
   logic          inv_ready;
   logic          clr_req;
   logic          clr_busy;
   logic          clr_done;
   logic          btb_ready;
   logic          btb_we;
   logic          btb_wvalid;
   logic [AW-1:0] btb_pc;
   logic [AW-1:0] btb_target;
   logic [2:0]    pend_cnt;

   typedef struct packed {
      logic          wv;
      logic [AW-1:0] pc;
      logic [AW-1:0] tgt;
      logic          done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   btb_update_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_pc      (ex_pc),
      .ex_target  (ex_target),
      .ex_taken   (ex_taken),
      .ex_ready   (ex_ready),
      .inv_valid  (inv_valid),
      .inv_pc     (inv_pc),
      .inv_ready  (inv_ready),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .btb_ready  (btb_ready),
      .btb_we     (btb_we),
      .btb_wvalid (btb_wvalid),
      .btb_pc     (btb_pc),
      .btb_target (btb_target),
      .pend_cnt   (pend_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic wv, input logic [AW-1:0] pc,
                           input logic [AW-1:0] tgt, input logic done);
      exp_t e;
      e.wv   = wv;
      e.pc   = pc;
      e.tgt  = tgt;
      e.done = done;
      exp_q.push_back(e);
   endtask

   // Monitor: every write must match the head of the scoreboard queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (btb_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual_pc=0x%0h required=no_write", btb_pc);
            end else begin
               e = exp_q.pop_front();
               chk("wr_wvalid", 32'(btb_wvalid), 32'(e.wv));
               chk("wr_pc",     btb_pc,          e.pc);
               chk("wr_target", btb_target,      e.tgt);
               chk("wr_clr_done", 32'(clr_done), 32'(e.done));
            end
         end else if (clr_done) begin
            checks++;
            failures++;
            $display("FAIL clr_done_without_write actual=1 required=0");
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      int gaps;

      rst       = 1'b1;
      ex_valid  = 1'b0;
      ex_pc     = '0;
      ex_target = '0;
      ex_taken  = 1'b0;
      inv_valid = 1'b0;
      inv_pc    = '0;
      clr_req   = 1'b0;
      btb_ready = 1'b0;

      // Reset state
      repeat (3) step();
      @(negedge clk);
      chk("rst_ex_ready",  32'(ex_ready),  0);
      chk("rst_inv_ready", 32'(inv_ready), 0);
      chk("rst_btb_we",    32'(btb_we),    0);
      chk("rst_pend_cnt",  32'(pend_cnt),  0);
      chk("rst_clr_busy",  32'(clr_busy),  0);
      chk("rst_btb_pc",    btb_pc,         0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ex_ready", 32'(ex_ready), 1);

      // Single install: push in N, write visible in N+2 only
      step();
      btb_ready = 1'b1;
      ex_valid  = 1'b1;
      ex_pc     = 32'h1C00_0040;
      ex_target = 32'h1C00_0100;
      ex_taken  = 1'b1;
      @(negedge clk);
      chk("inst_ex_ready", 32'(ex_ready), 1);
      push_exp(1'b1, 32'h1C00_0040, 32'h1C00_0100, 1'b0);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("inst_we_n1", 32'(btb_we), 0);
      step();
      @(negedge clk);
      chk("inst_we_n2", 32'(btb_we), 1);
      step();
      @(negedge clk);
      chk("inst_we_n3", 32'(btb_we), 0);

      // Full FIFO and back-pressure
      step();
      btb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ex_valid  = 1'b1;
         ex_pc     = 32'h100 + 32'(4 * i);
         ex_target = 32'h1000 + 32'(16 * i);
         ex_taken  = 1'b1;
         @(negedge clk);
         chk("full_fill_ready", 32'(ex_ready), 1);
         push_exp(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(16 * i), 1'b0);
         step();
      end
      ex_pc     = 32'h110;
      ex_target = 32'h1040;
      @(negedge clk);
      chk("full_pend_cnt",  32'(pend_cnt),  4);
      chk("full_ex_ready",  32'(ex_ready),  0);
      chk("full_inv_ready", 32'(inv_ready), 0);
      step();
      @(negedge clk);
      chk("full_held", 32'(ex_ready), 0);
      step();
      btb_ready = 1'b1;
      @(negedge clk);
      chk("full_no_bypass", 32'(ex_ready), 0);
      step();
      @(negedge clk);
      chk("fifth_ready",    32'(ex_ready), 1);
      chk("fifth_pend_cnt", 32'(pend_cnt), 3);
      push_exp(1'b1, 32'h110, 32'h1040, 1'b0);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("push_pop_pend_cnt", 32'(pend_cnt), 3);
      repeat (6) step();
      @(negedge clk);
      chk("full_drained_cnt", 32'(pend_cnt), 0);
      chk("full_q_empty", 32'(exp_q.size()), 0);

      // EX has priority over invalidate
      step();
      ex_valid  = 1'b1;
      ex_pc     = 32'h200;
      ex_target = 32'h2200;
      ex_taken  = 1'b1;
      inv_valid = 1'b1;
      inv_pc    = 32'h300;
      @(negedge clk);
      chk("prio_inv_ready_blocked", 32'(inv_ready), 0);
      chk("prio_ex_ready",          32'(ex_ready),  1);
      push_exp(1'b1, 32'h200, 32'h2200, 1'b0);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("prio_inv_ready_next", 32'(inv_ready), 1);
      push_exp(1'b0, 32'h300, 32'h0, 1'b0);
      step();
      inv_valid = 1'b0;
      repeat (4) step();

      // Not-taken EX writes an invalidate carrying the resolved target
      ex_valid  = 1'b1;
      ex_pc     = 32'h1C00_0080;
      ex_target = 32'h1C00_0FF0;
      ex_taken  = 1'b0;
      push_exp(1'b0, 32'h1C00_0080, 32'h1C00_0FF0, 1'b0);
      step();
      ex_valid = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("nt_q_empty", 32'(exp_q.size()), 0);

      // Clear with two pending entries
      step();
      btb_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ex_valid  = 1'b1;
         ex_pc     = 32'h400 + 32'(4 * i);
         ex_target = 32'h4400 + 32'(4 * i);
         ex_taken  = 1'b1;
         push_exp(1'b1, 32'h400 + 32'(4 * i), 32'h4400 + 32'(4 * i), 1'b0);
         step();
      end
      ex_valid = 1'b0;
      clr_req  = 1'b1;
      for (int k = 0; k < 64; k++)
         push_exp(1'b0, 32'(4 * k), 32'h0, (k == 63));
      step();
      clr_req   = 1'b0;
      btb_ready = 1'b1;
      @(negedge clk);
      chk("drain_busy",     32'(clr_busy), 1);
      chk("drain_ex_ready", 32'(ex_ready), 0);
      step();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (btb_we && !btb_wvalid && btb_pc == 32'h0) found = 1'b1;
         else step();
      end
      chk("clr_first_write_seen", 32'(found), 1);
      gaps = 0;
      for (int k = 1; k < 64; k++) begin
         step();
         if (k == 5) clr_req = 1'b1;
         if (k == 6) clr_req = 1'b0;
         @(negedge clk);
         if (!btb_we) gaps++;
      end
      chk("clr_gaps",       32'(gaps),     0);
      chk("clr_done_last",  32'(clr_done), 1);
      chk("clr_last_pc",    btb_pc,        32'hFC);
      chk("clr_end_busy",   32'(clr_busy), 0);
      chk("clr_end_ready",  32'(ex_ready), 1);
      step();
      @(negedge clk);
      chk("clr_after_we",   32'(btb_we),   0);
      repeat (4) step();
      @(negedge clk);
      chk("clr_ignored_busy", 32'(clr_busy), 0);
      chk("clr_q_empty", 32'(exp_q.size()), 0);

      // Reset in the middle of a clear
      step();
      clr_req = 1'b1;
      for (int k = 0; k <= 10; k++)
         push_exp(1'b0, 32'(4 * k), 32'h0, 1'b0);
      step();
      clr_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (btb_we && btb_pc == 32'h28) found = 1'b1;
         else step();
      end
      chk("mid_idx10_seen", 32'(found), 1);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("mid_rst_we",       32'(btb_we),   0);
      chk("mid_rst_busy",     32'(clr_busy), 0);
      chk("mid_rst_pend_cnt", 32'(pend_cnt), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_post_ex_ready",  32'(ex_ready),  1);
      chk("mid_post_inv_ready", 32'(inv_ready), 1);
      repeat (20) step();
      @(negedge clk);
      chk("mid_no_more_busy", 32'(clr_busy), 0);
      chk("final_q_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
